// File: rtl/acc_loop_ctrl.sv
// acc_loop_ctrl: row/pass/tile sequencer for the accumulation datapath.
// Optional perf counters enabled by defining ACC_CTRL_PERF_EN.
module acc_loop_ctrl #(
  parameter int H_W   = 8,
  parameter int A_W   = 10,
  parameter int T_W   = 16,
  parameter int OUT_W = 26
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [H_W-1:0] cfg_height,
  input  logic [A_W-1:0] cfg_acc,
  input  logic [T_W-1:0] cfg_tiles,
  input  logic           psum_vld,
  output logic           psum_rdy,
  output logic           acc_vld,
  output logic           height_loop_end,
  output logic           acc_loop_max,
  output logic           acc_and_height_loop_end,
  input  logic           acc_out_vld,
  output logic           busy,
  output logic           done
`ifdef ACC_CTRL_PERF_EN
  ,
  output logic [31:0]    perf_stall_cnt,
  output logic [31:0]    perf_run_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [H_W-1:0]   h_q, h_d;
  logic [A_W-1:0]   a_q, a_d;
  logic [T_W-1:0]   t_q, t_d;
  logic [H_W-1:0]   cfg_h_q, cfg_h_d;
  logic [A_W-1:0]   cfg_a_q, cfg_a_d;
  logic [T_W-1:0]   cfg_t_q, cfg_t_d;
  logic [OUT_W-1:0] total_q, total_d;
  logic [OUT_W-1:0] out_cnt_q, out_cnt_d;

  logic h_end;
  logic a_end;
  logic t_end;
  logic last_beat;
  logic start_ok;
  logic out_cnt_en;

  logic [OUT_W-1:0] tiles_ext;
  logic [OUT_W-1:0] rows_ext;

  assign h_end     = (h_q == cfg_h_q);
  assign a_end     = (a_q == cfg_a_q);
  assign t_end     = (t_q == cfg_t_q);
  assign start_ok  = start & (state_q == S_IDLE);
  assign tiles_ext = OUT_W'(cfg_tiles) + OUT_W'(1);
  assign rows_ext  = OUT_W'(cfg_height) + OUT_W'(1);

  // handshake and datapath strobes, all zero-latency
  always_comb begin
    psum_rdy                = (state_q == S_RUN);
    acc_vld                 = psum_vld & psum_rdy;
    height_loop_end         = acc_vld & h_end;
    acc_loop_max            = acc_vld & a_end;
    acc_and_height_loop_end = height_loop_end & a_end;
    last_beat               = acc_vld & h_end & a_end & t_end;
    busy                    = (state_q != S_IDLE);
    done                    = (state_q == S_DONE);
  end

  // drained outputs only count while a job is live
  always_comb begin
    out_cnt_en = acc_out_vld &
                 ((state_q == S_RUN) | (state_q == S_DRAIN));
  end

  // next-state, config latch and loop counters
  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    a_d       = a_q;
    t_d       = t_q;
    cfg_h_d   = cfg_h_q;
    cfg_a_d   = cfg_a_q;
    cfg_t_d   = cfg_t_q;
    total_d   = total_q;
    out_cnt_d = out_cnt_q;

    if (out_cnt_en) begin
      out_cnt_d = out_cnt_q + OUT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d   = S_RUN;
          cfg_h_d   = cfg_height;
          cfg_a_d   = cfg_acc;
          cfg_t_d   = cfg_tiles;
          total_d   = tiles_ext * rows_ext;
          h_d       = '0;
          a_d       = '0;
          t_d       = '0;
          out_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (acc_vld) begin
          if (h_end) begin
            h_d = '0;
            if (a_end) begin
              a_d = '0;
              t_d = t_end ? '0 : t_q + T_W'(1);
            end else begin
              a_d = a_q + A_W'(1);
            end
          end else begin
            h_d = h_q + H_W'(1);
          end
        end
        if (last_beat) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // leave as soon as the final output lands, or at once if
        // every output already arrived while beats were streaming
        if ((out_cnt_q == total_q) || (out_cnt_d == total_q)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      h_q       <= '0;
      a_q       <= '0;
      t_q       <= '0;
      cfg_h_q   <= '0;
      cfg_a_q   <= '0;
      cfg_t_q   <= '0;
      total_q   <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      a_q       <= a_d;
      t_q       <= t_d;
      cfg_h_q   <= cfg_h_d;
      cfg_a_q   <= cfg_a_d;
      cfg_t_q   <= cfg_t_d;
      total_q   <= total_d;
      out_cnt_q <= out_cnt_d;
    end
  end

`ifdef ACC_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] run_q, run_d;

  // saturating run/stall cycle counters, cleared by a new job
  always_comb begin
    stall_d = stall_q;
    run_d   = run_q;
    if (start_ok) begin
      stall_d = '0;
      run_d   = '0;
    end else begin
      if (((state_q == S_RUN) | (state_q == S_DRAIN)) &&
          (run_q != 32'hFFFF_FFFF)) begin
        run_d = run_q + 32'd1;
      end
      if ((state_q == S_RUN) && !psum_vld &&
          (stall_q != 32'hFFFF_FFFF)) begin
        stall_d = stall_q + 32'd1;
      end
    end
  end

  // perf register update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      run_q   <= '0;
    end else begin
      stall_q <= stall_d;
      run_q   <= run_d;
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_run_cnt   = run_q;
`endif

endmodule
